// File: rtl/shared_op_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : shared_op_arbiter
//  Description : Round-robin arbiter that shares one arithmetic unit
//                (ADD/SUB/MUL single-cycle, DIV/MOD iterative) between two
//                requesters and returns each result tagged with the
//                requester ID.
//  Options     : SHARED_OP_ARBITER_DIV_EN - build the iterative restoring
//                divider; when undefined DIV/MOD report resp_err.
//  Revision    : 1.0 - initial release
// ============================================================================
module shared_op_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_a_valid,
    input  logic [2:0]       req_a_op,
    input  logic [WIDTH-1:0] req_a_lhs,
    input  logic [WIDTH-1:0] req_a_rhs,
    output logic             req_a_ready,
    input  logic             req_b_valid,
    input  logic [2:0]       req_b_op,
    input  logic [WIDTH-1:0] req_b_lhs,
    input  logic [WIDTH-1:0] req_b_rhs,
    output logic             req_b_ready,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_id,
    output logic             resp_err
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_MUL = 3'd2;
`ifdef SHARED_OP_ARBITER_DIV_EN
    localparam logic [2:0] OP_DIV = 3'd3;
    localparam logic [2:0] OP_MOD = 3'd4;
`endif

    localparam logic [1:0] S_IDLE   = 2'd0;
`ifdef SHARED_OP_ARBITER_DIV_EN
    localparam logic [1:0] S_DIVIDE = 2'd1;
`endif
    localparam logic [1:0] S_DONE   = 2'd2;

    // Common control / response state
    logic [1:0]       state_q,      state_d;
    logic             last_grant_q, last_grant_d;   // 0 = A, 1 = B
    logic [WIDTH-1:0] resp_data_q,  resp_data_d;
    logic             resp_id_q,    resp_id_d;
    logic             resp_err_q,   resp_err_d;

    // Arbitration and selected-request datapath
    logic             grant_b;
    logic             accept;
    logic [2:0]       sel_op;
    logic [WIDTH-1:0] sel_lhs;
    logic [WIDTH-1:0] sel_rhs;
    logic [WIDTH-1:0] fast_data;
    logic             fast_err;

`ifdef SHARED_OP_ARBITER_DIV_EN
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    // Divider state: quo_q starts as the dividend magnitude and fills with
    // quotient bits from the bottom while the dividend shifts out the top.
    logic [WIDTH-1:0] quo_q,      quo_d;
    logic [WIDTH-1:0] rem_q,      rem_d;
    logic [WIDTH-1:0] dvs_q,      dvs_d;
    logic [CW-1:0]    cnt_q,      cnt_d;
    logic             is_mod_q,   is_mod_d;
    logic             neg_quo_q,  neg_quo_d;
    logic             neg_rem_q,  neg_rem_d;

    logic             start_div;
    logic [WIDTH-1:0] rem_shift;
    logic             trial_ge;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic [WIDTH-1:0] div_result;
`endif

    // Arbitration: a lone requester wins; on a tie the one not granted last wins
    always_comb begin
        grant_b     = req_b_valid && (!req_a_valid || !last_grant_q);
        req_a_ready = (state_q == S_IDLE) && !reset && req_a_valid && !grant_b;
        req_b_ready = (state_q == S_IDLE) && !reset && grant_b;
        accept      = req_a_ready || req_b_ready;
        sel_op      = grant_b ? req_b_op  : req_a_op;
        sel_lhs     = grant_b ? req_b_lhs : req_a_lhs;
        sel_rhs     = grant_b ? req_b_rhs : req_a_rhs;
    end

    // Single-cycle ops and error detection for the selected request
    always_comb begin
        fast_data = '0;
        fast_err  = 1'b0;
`ifdef SHARED_OP_ARBITER_DIV_EN
        start_div = 1'b0;
`endif
        case (sel_op)
            OP_ADD: fast_data = sel_lhs + sel_rhs;
            OP_SUB: fast_data = sel_lhs - sel_rhs;
            OP_MUL: fast_data = sel_lhs * sel_rhs;
`ifdef SHARED_OP_ARBITER_DIV_EN
            OP_DIV, OP_MOD: begin
                if (sel_rhs == '0) begin
                    fast_err = 1'b1;
                end else begin
                    start_div = 1'b1;
                end
            end
`endif
            default: fast_err = 1'b1;
        endcase
    end

`ifdef SHARED_OP_ARBITER_DIV_EN
    // One restoring-division step on magnitudes plus the final sign fix-up
    always_comb begin
        rem_shift  = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
        trial_ge   = {rem_q, quo_q[WIDTH-1]} >= {1'b0, dvs_q};
        rem_next   = trial_ge ? (rem_shift - dvs_q) : rem_shift;
        quo_next   = {quo_q[WIDTH-2:0], trial_ge};
        // INT_MIN / -1 naturally wraps back to INT_MIN here
        if (is_mod_q) begin
            div_result = neg_rem_q ? (-rem_next) : rem_next;
        end else begin
            div_result = neg_quo_q ? (-quo_next) : quo_next;
        end
    end
`endif

    // Next-state logic for the IDLE / DIVIDE / DONE sequencer
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        resp_err_d   = resp_err_q;
`ifdef SHARED_OP_ARBITER_DIV_EN
        quo_d        = quo_q;
        rem_d        = rem_q;
        dvs_d        = dvs_q;
        cnt_d        = cnt_q;
        is_mod_d     = is_mod_q;
        neg_quo_d    = neg_quo_q;
        neg_rem_d    = neg_rem_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    last_grant_d = grant_b;
                    resp_id_d    = grant_b;
`ifdef SHARED_OP_ARBITER_DIV_EN
                    if (start_div) begin
                        quo_d     = sel_lhs[WIDTH-1] ? (-sel_lhs) : sel_lhs;
                        dvs_d     = sel_rhs[WIDTH-1] ? (-sel_rhs) : sel_rhs;
                        rem_d     = '0;
                        cnt_d     = '0;
                        is_mod_d  = (sel_op == OP_MOD);
                        neg_quo_d = sel_lhs[WIDTH-1] ^ sel_rhs[WIDTH-1];
                        neg_rem_d = sel_lhs[WIDTH-1];
                        state_d   = S_DIVIDE;
                    end else begin
                        resp_data_d = fast_data;
                        resp_err_d  = fast_err;
                        state_d     = S_DONE;
                    end
`else
                    resp_data_d = fast_data;
                    resp_err_d  = fast_err;
                    state_d     = S_DONE;
`endif
                end
            end
`ifdef SHARED_OP_ARBITER_DIV_EN
            S_DIVIDE: begin
                quo_d = quo_next;
                rem_d = rem_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    resp_data_d = div_result;
                    resp_err_d  = 1'b0;
                    state_d     = S_DONE;
                end
            end
`endif
            S_DONE: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset; an in-flight op is simply dropped
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= S_IDLE;
            last_grant_q <= 1'b1;
            resp_data_q  <= '0;
            resp_id_q    <= 1'b0;
            resp_err_q   <= 1'b0;
`ifdef SHARED_OP_ARBITER_DIV_EN
            quo_q        <= '0;
            rem_q        <= '0;
            dvs_q        <= '0;
            cnt_q        <= '0;
            is_mod_q     <= 1'b0;
            neg_quo_q    <= 1'b0;
            neg_rem_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            resp_err_q   <= resp_err_d;
`ifdef SHARED_OP_ARBITER_DIV_EN
            quo_q        <= quo_d;
            rem_q        <= rem_d;
            dvs_q        <= dvs_d;
            cnt_q        <= cnt_d;
            is_mod_q     <= is_mod_d;
            neg_quo_q    <= neg_quo_d;
            neg_rem_q    <= neg_rem_d;
`endif
        end
    end

    assign resp_valid = (state_q == S_DONE);
    assign resp_data  = resp_data_q;
    assign resp_id    = resp_id_q;
    assign resp_err   = resp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_shared_op_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_shared_op_arbiter
//  Description : Directed self-checking bench for shared_op_arbiter.
//                DIV/MOD expectations follow SHARED_OP_ARBITER_DIV_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_shared_op_arbiter;

    localparam int W = 32;

    localparam logic [2:0] ADD = 3'd0;
    localparam logic [2:0] SUB = 3'd1;
    localparam logic [2:0] MUL = 3'd2;
    localparam logic [2:0] DIV = 3'd3;
    localparam logic [2:0] MOD = 3'd4;
    localparam logic [2:0] BAD = 3'd7;

    localparam logic [W-1:0] INT_MIN = 32'h8000_0000;
    localparam logic [W-1:0] NEG1    = 32'hFFFF_FFFF;

    logic         clock = 1'b0;
    logic         reset;
    logic         req_a_valid, req_b_valid;
    logic [2:0]   req_a_op, req_b_op;
    logic [W-1:0] req_a_lhs, req_a_rhs, req_b_lhs, req_b_rhs;
    logic         req_a_ready, req_b_ready;
    logic         resp_valid, resp_ready;
    logic [W-1:0] resp_data;
    logic         resp_id, resp_err;

    int tests = 0;
    int fails = 0;

    shared_op_arbiter #(.WIDTH(W)) dut (
        .clock       (clock),
        .reset       (reset),
        .req_a_valid (req_a_valid),
        .req_a_op    (req_a_op),
        .req_a_lhs   (req_a_lhs),
        .req_a_rhs   (req_a_rhs),
        .req_a_ready (req_a_ready),
        .req_b_valid (req_b_valid),
        .req_b_op    (req_b_op),
        .req_b_lhs   (req_b_lhs),
        .req_b_rhs   (req_b_rhs),
        .req_b_ready (req_b_ready),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .resp_data   (resp_data),
        .resp_id     (resp_id),
        .resp_err    (resp_err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Sample point in the middle of the current cycle
    task automatic smp();
        @(negedge clock);
    endtask

    task automatic drive_a(input logic v, input logic [2:0] op, input logic [W-1:0] l, input logic [W-1:0] r);
        req_a_valid = v; req_a_op = op; req_a_lhs = l; req_a_rhs = r;
    endtask

    task automatic drive_b(input logic v, input logic [2:0] op, input logic [W-1:0] l, input logic [W-1:0] r);
        req_b_valid = v; req_b_op = op; req_b_lhs = l; req_b_rhs = r;
    endtask

    // Issue one request from an idle cycle and check its response timing
    task automatic one_op(input string tag, input logic use_b, input logic [2:0] op,
                          input logic [W-1:0] l, input logic [W-1:0] r, input int lat,
                          input logic [W-1:0] exp_data, input logic exp_err);
        int early;
        early = 0;
        if (use_b) drive_b(1'b1, op, l, r); else drive_a(1'b1, op, l, r);
        smp();
        chk({tag, "_ready"}, use_b ? req_b_ready : req_a_ready, 1);
        step();
        drive_a(1'b0, ADD, '0, '0);
        drive_b(1'b0, ADD, '0, '0);
        for (int i = 1; i < lat; i++) begin
            smp();
            if (resp_valid || req_a_ready || req_b_ready) early++;
            step();
        end
        if (lat > 1) chk({tag, "_busy_quiet"}, early, 0);
        smp();
        chk({tag, "_valid"}, resp_valid, 1);
        chk({tag, "_data"}, resp_data, exp_data);
        chk({tag, "_id"}, resp_id, use_b);
        chk({tag, "_err"}, resp_err, exp_err);
        step();
    endtask

    initial begin
        reset = 1'b1;
        resp_ready = 1'b0;
        drive_a(1'b0, ADD, '0, '0);
        drive_b(1'b0, ADD, '0, '0);
        step();
        step();

        // Reset state: ready must stay low while reset is high even if valid
        drive_a(1'b1, ADD, 7, 13);
        resp_ready = 1'b1;
        smp();
        chk("rst_a_ready", req_a_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_err", resp_err, 0);
        step();
        reset = 1'b0;

        // ADD 7,13 from A, response in T+1
        smp();
        chk("add_a_ready", req_a_ready, 1);
        chk("add_b_ready", req_b_ready, 0);
        chk("add_pre_valid", resp_valid, 0);
        step();
        drive_a(1'b0, ADD, '0, '0);
        smp();
        chk("add_valid", resp_valid, 1);
        chk("add_data", resp_data, 20);
        chk("add_id", resp_id, 0);
        chk("add_err", resp_err, 0);
        step();
        smp();
        chk("add_idle_after_hs", resp_valid, 0);

        // Fresh reset, then simultaneous requests: A wins the first tie
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive_a(1'b1, ADD, 1, 2);
        drive_b(1'b1, MUL, 20, 13);
        smp();
        chk("tie_a_ready", req_a_ready, 1);
        chk("tie_b_ready", req_b_ready, 0);
        step();
        drive_a(1'b0, ADD, '0, '0);
        smp();
        chk("tie_a_data", resp_data, 3);
        chk("tie_a_id", resp_id, 0);
        chk("done_b_ready", req_b_ready, 0);
        step();
        smp();
        chk("tie_b_ready2", req_b_ready, 1);
        step();
        drive_b(1'b0, ADD, '0, '0);
        smp();
        chk("mul_data", resp_data, 260);
        chk("mul_id", resp_id, 1);
        chk("mul_err", resp_err, 0);
        step();

        // Alternation: last grant was B so A wins, then B wins the next tie
        drive_a(1'b1, SUB, 7, 13);
        drive_b(1'b1, ADD, 5, 5);
        smp();
        chk("alt1_a_ready", req_a_ready, 1);
        step();
        drive_a(1'b1, ADD, 1, 1);
        smp();
        chk("sub_data", resp_data, -6);
        chk("sub_id", resp_id, 0);
        step();
        smp();
        chk("alt2_b_ready", req_b_ready, 1);
        chk("alt2_a_ready", req_a_ready, 0);
        step();
        drive_b(1'b0, ADD, '0, '0);
        smp();
        chk("alt2_data", resp_data, 10);
        chk("alt2_id", resp_id, 1);
        step();
        smp();
        chk("alt3_a_ready", req_a_ready, 1);
        step();
        drive_a(1'b0, ADD, '0, '0);
        smp();
        chk("alt3_data", resp_data, 2);
        chk("alt3_id", resp_id, 0);
        step();

        // Error cases: divide by zero and illegal op respond in T+1
        one_op("div0", 1'b0, DIV, 5, 0, 1, 0, 1'b1);
        one_op("illegal", 1'b1, BAD, 9, 9, 1, 0, 1'b1);
        one_op("mul_wrap", 1'b0, MUL, 32'h0001_0000, 32'h0001_0003, 1, 32'h0003_0000, 1'b0);

`ifdef SHARED_OP_ARBITER_DIV_EN
        one_op("div_neg", 1'b1, DIV, -260, 13, W + 1, -20, 1'b0);
        one_op("mod_neg", 1'b1, MOD, 260, -22, W + 1, 18, 1'b0);
        one_op("mod_lneg", 1'b0, MOD, -7, 3, W + 1, -1, 1'b0);
        one_op("div_min", 1'b0, DIV, INT_MIN, NEG1, W + 1, INT_MIN, 1'b0);
        one_op("mod_min", 1'b1, MOD, INT_MIN, NEG1, W + 1, 0, 1'b0);
`else
        one_op("div_off", 1'b0, DIV, 100, 22, 1, 0, 1'b1);
        one_op("mod_off", 1'b1, MOD, 100, 22, 1, 0, 1'b1);
`endif

        // Back-pressure: hold resp_ready low for 5 cycles in DONE
        resp_ready = 1'b0;
        drive_a(1'b1, ADD, 3, 4);
        drive_b(1'b1, SUB, 10, 3);
        step();
        drive_a(1'b0, ADD, '0, '0);
        for (int i = 0; i < 5; i++) begin
            smp();
            chk("hold_valid", resp_valid, 1);
            chk("hold_data", resp_data, 7);
            chk("hold_id", resp_id, 0);
            chk("hold_rdy", {req_a_ready, req_b_ready}, 0);
            step();
        end
        resp_ready = 1'b1;
        smp();
        chk("hs_cycle_b_ready", req_b_ready, 0);
        step();
        smp();
        chk("hs_idle_valid", resp_valid, 0);
        chk("hs_idle_b_ready", req_b_ready, 1);
        step();
        drive_b(1'b0, ADD, '0, '0);
        smp();
        chk("held_b_data", resp_data, 7);
        chk("held_b_id", resp_id, 1);
        step();

        // Reset while in DONE drops the response
        resp_ready = 1'b0;
        drive_a(1'b1, ADD, 1, 1);
        step();
        drive_a(1'b0, ADD, '0, '0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        resp_ready = 1'b1;
        smp();
        chk("rst_done_valid", resp_valid, 0);

`ifdef SHARED_OP_ARBITER_DIV_EN
        // Reset in the middle of a divide drops it; IDLE right afterwards
        step();
        drive_a(1'b1, DIV, 100, 7);
        step();
        drive_a(1'b0, ADD, '0, '0);
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive_a(1'b1, ADD, 2, 2);
        smp();
        chk("rst_div_valid", resp_valid, 0);
        chk("rst_div_a_ready", req_a_ready, 1);
        step();
        drive_a(1'b0, ADD, '0, '0);
        smp();
        chk("rst_div_data", resp_data, 4);
        chk("rst_div_err", resp_err, 0);
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/shared_op_arbiter.md
# shared_op_arbiter

Round-robin arbiter and sequencer that shares one arithmetic unit (add, sub, mul, div, mod) between two requesters. Add, sub and mul complete in one cycle. Div and mod run on an iterative restoring divider that takes WIDTH cycles. Sits between the register-update logic of two client modules and a single arithmetic datapath, and returns each result with the ID of the requester that issued it.

## Interface
Parameters:
- WIDTH, 32, operand and result width; signed two's-complement.

Ports:
- clock  in  1  global clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset; sampled on the rising edge of clock.
- req_a_valid  in  1  requester A has an operation pending.
- req_a_op  in  3  op code: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 MOD, 5-7 illegal.
- req_a_lhs  in  WIDTH  left operand.
- req_a_rhs  in  WIDTH  right operand.
- req_a_ready  out  1  request A accepted this cycle when valid and ready are both high.
- req_b_valid, req_b_op, req_b_lhs, req_b_rhs, req_b_ready: same as the A ports, for requester B.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_data  out  WIDTH  result.
- resp_id  out  1  0 = A, 1 = B.
- resp_err  out  1  divide by zero, illegal op, or DIV/MOD compiled out.

## Operation
- State machine: IDLE, DIVIDE, DONE.
- IDLE:
  - Grant selection: if exactly one requester is valid, it is granted. If both are valid, grant the one not granted last (last_grant register).
  - req_x_ready is combinational: high only in IDLE and only for the granted requester.
  - On accept: latch op, operands and ID.
  - ADD, SUB, MUL: result computed and registered on the accept edge; go to DONE.
  - DIV or MOD with rhs != 0: go to DIVIDE.
  - DIV or MOD with rhs == 0, or an illegal op: resp_err=1, resp_data=0, go to DONE.
- Arithmetic:
  - ADD, SUB, MUL wrap modulo 2^WIDTH. MUL keeps the low WIDTH bits.
  - DIV truncates toward zero; MOD takes the sign of lhs (C semantics).
  - INT_MIN / -1 gives INT_MIN; INT_MIN % -1 gives 0; resp_err=0 in both cases.
- DIVIDE:
  - Works on magnitudes, one quotient bit per cycle, for exactly WIDTH cycles.
  - Signs are fixed up on the last iteration edge, then go to DONE.
- DONE:
  - resp_valid=1. resp_data, resp_id and resp_err stay stable until resp_valid and resp_ready are both high.
  - On that handshake, go to IDLE.
  - No request is accepted in DONE or DIVIDE, including the handshake cycle.
- last_grant updates only on accept.

## Timing
- Reset values: state IDLE, resp_valid=0, resp_data=0, resp_id=0, resp_err=0, last_grant=B (so A wins the first tie). req_a_ready and req_b_ready are 0 for the cycle reset is high.
- Accept on the edge ending cycle T:
  - ADD, SUB, MUL and error cases: resp_valid high in cycle T+1.
  - DIV, MOD: resp_valid high in cycle T+1+WIDTH.
- Throughput: with resp_ready held high, one operation per 2 cycles (single-cycle ops), or per WIDTH+2 cycles (DIV/MOD).
- A requester that drops valid before being accepted loses nothing; no request is ever latched without a handshake.
- Reset in DIVIDE or DONE: the operation is dropped with no response, and the block is in IDLE the next cycle.

## Configuration
- SHARED_OP_ARBITER_DIV_EN:
  - Defined: the iterative divider and the DIVIDE state are built, and DIV/MOD behave as specified above.
  - Undefined: no divider is built. DIV and MOD are handled like illegal ops: response in T+1 with resp_err=1 and resp_data=0. ADD, SUB and MUL are unchanged.

## Test plan
- Reset, then A issues ADD 7,13 with resp_ready=1 -> resp_valid in T+1, resp_data=20, resp_id=0, resp_err=0.
- A and B both valid in the same cycle after reset -> A granted first; B granted on the next IDLE cycle; B's MUL 20,13 returns 260 with resp_id=1.
- B issues DIV -260,13, then MOD 260,-22 (DIV_EN defined) -> -20 after WIDTH+1 cycles; 18 with resp_err=0.
- A issues DIV 5,0 -> resp_err=1, resp_data=0 in T+1. INT_MIN/-1 -> INT_MIN with resp_err=0.
- Hold resp_ready=0 for 5 cycles in DONE -> outputs stable, both ready signals low; resp_ready=1 -> IDLE next cycle. Reset pulsed mid-DIVIDE -> no response; IDLE the next cycle.
- Build with DIV_EN undefined: DIV 100,22 -> resp_err=1 in T+1; SUB 7,13 -> -6.
